// File: rtl/fft_frame_serializer.sv
// Serializes an 8-word parallel FFT frame onto a valid/ready stream,
// optionally in 3-bit bit-reversed index order, with overrun and frame count.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   frame_i[0:7]      parallel frame words, captured on a frame_valid_i rise
//   frame_valid_i     level; a low-to-high transition marks a new frame
//   m_data_o          serial word (registered buffer, decoded by beat)
//   m_valid_o         word valid
//   m_ready_i         downstream accept
//   m_last_o          eighth word of the frame
//   m_index_o         frame index of the word on m_data_o
//   busy_o            frame in progress
//   overrun_o         sticky: a frame arrived while busy and was dropped
//   frames_o          count of fully emitted frames (wraps)
module fft_frame_serializer #(
  parameter int DATA_WIDTH  = 50,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] frame_i [0:7],
  input  logic                  frame_valid_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic [2:0]            m_index_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [15:0]           frames_o
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_nxt;

  logic [2:0]            beat, beat_nxt;
  logic [2:0]            addr;
  logic                  prev;
  logic                  rise;
  logic                  capture;
  logic                  ovr_set;
  logic                  frame_done;
  logic [DATA_WIDTH-1:0] buffer [0:7];

  assign rise = frame_valid_i & ~prev;
  assign addr = BIT_REVERSE ? {beat[0], beat[1], beat[2]} : beat;

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    capture    = 1'b0;
    ovr_set    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          capture   = 1'b1;
          beat_nxt  = 3'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (m_ready_i && beat == 3'd7) begin
          frame_done = 1'b1;
          beat_nxt   = 3'd0;
          // A rise on the closing transfer chains straight into the next frame.
          if (rise) capture = 1'b1;
          else state_nxt = IDLE;
        end else begin
          if (m_ready_i) beat_nxt = beat + 3'd1;
          ovr_set = rise;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      beat      <= 3'd0;
      prev      <= 1'b0;
      overrun_o <= 1'b0;
      frames_o  <= 16'd0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      prev  <= frame_valid_i;
      if (ovr_set) overrun_o <= 1'b1;
      if (frame_done) frames_o <= frames_o + 16'd1;
    end
  end

  // Buffer needs no reset: it is only visible once a frame is captured.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      for (int k = 0; k < 8; k++) buffer[k] <= frame_i[k];
    end
  end

  assign busy_o    = (state == SEND);
  assign m_valid_o = busy_o;
  assign m_last_o  = busy_o && (beat == 3'd7);
  assign m_index_o = busy_o ? addr : 3'd0;
  assign m_data_o  = busy_o ? buffer[addr] : '0;

endmodule
